// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity-type constants and the default frame data width.
package uart_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the data portion of a frame.
// bit_now is the LSB of the held word; next_bit is what appears after one shift.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [Data_width-1:0] data,
    output logic                  bit_now,
    output logic                  next_bit,
    output logic                  done
);

    localparam int CW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [CW-1:0] LAST = CW'(Data_width - 1);

    logic [Data_width-1:0] sreg;
    logic [CW-1:0]         cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {1'b0, sreg[Data_width-1:1]};
            cnt  <= cnt + 1'b1;
        end
    end

    assign bit_now  = sreg[0];
    assign next_bit = sreg[1];
    // cnt tracks the index of the bit currently on the line while in DATA.
    assign done     = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter clocked at the baud rate: start, LSB-first data, optional
// parity, stop. TX_OUT and Busy are flops fed from the next-state decode.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            state_dbg
);

    // Handshake: a word is accepted on any rising edge where Data_Valid=1 and
    // the FSM is in IDLE (Busy=0); Data_Valid in any other state is dropped.

    tx_state_e state, next_state;

    logic par_en_q;
    logic par_bit_q;
    logic load, shift, done;
    logic bit_now, next_bit;
    logic next_tx, next_busy;

    uart_tx_serializer #(
        .Data_width (Data_width)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift    (shift),
        .data     (P_DATA),
        .bit_now  (bit_now),
        .next_bit (next_bit),
        .done     (done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= next_tx;
            Busy   <= next_busy;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
            end
        end
    end

    // Outputs are decoded from the state being entered, so the registered
    // line value lines up with the registered state.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        next_tx    = 1'b1;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    next_state = START;
                    load       = 1'b1;
                    next_tx    = 1'b0;
                end
            end
            START: begin
                next_state = DATA;
                next_tx    = bit_now;
            end
            DATA: begin
                if (done) begin
                    next_state = par_en_q ? PARITY : STOP;
                    next_tx    = par_en_q ? par_bit_q : 1'b1;
                end else begin
                    shift   = 1'b1;
                    next_tx = next_bit;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        next_busy = (next_state != IDLE);
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames, rejection, back-to-back,
// mid-frame reset and random traffic, checked by a queue-fed line monitor.
module tb_uart_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         Busy;
    logic [2:0]   state_dbg;

    uart_tx #(
        .Data_width (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset bookkeeping
    always #5 CLK = ~CLK;

    int edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;
    int next_free = 0;
    bit in_frame = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_par_q[$];
    int           exp_edge_q[$];

    // reference model
    function automatic logic ref_parity(input logic [W-1:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        if (typ) return ((ones % 2) == 0);
        return ((ones % 2) == 1);
    endfunction

    function automatic int frame_len(input logic pen);
        return W + 2 + (pen ? 1 : 0);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // driver tasks
    task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                               input logic pen, input logic typ);
        @(negedge CLK);
        Data_Valid = v;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = typ;
        if (v && RST && (edge_cnt + 1) >= next_free) begin
            exp_q.push_back(d);
            exp_par_q.push_back({pen, ref_parity(d, typ)});
            exp_edge_q.push_back(edge_cnt + 1);
            next_free = edge_cnt + 1 + frame_len(pen) + 1;
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [W-1:0] d, input logic pen, input logic typ);
        drive_cycle(1'b1, d, pen, typ);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 40 && (edge_cnt + 1) < next_free; i++) idle_cycle();
    endtask

    task automatic release_reset();
        @(negedge CLK);
        Data_Valid = 1'b0;
        RST        = 1'b1;
        next_free  = 0;
    endtask

    // scoreboard monitor
    initial begin
        logic [W+2:0] bits;
        logic [W-1:0] d;
        logic [1:0]   pp;
        int           len;
        int           pos;
        pos = 0;
        len = 0;
        bits = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (!RST) begin
                in_frame = 1'b0;
                check("reset_tx", TX_OUT, 1'b1);
                check("reset_busy", Busy, 1'b0);
            end else begin
                while (!in_frame && exp_edge_q.size() > 0 && exp_edge_q[0] < edge_cnt) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stale_frame: start edge %0d never seen, now %0d",
                             exp_edge_q[0], edge_cnt);
                    void'(exp_q.pop_front());
                    void'(exp_par_q.pop_front());
                    void'(exp_edge_q.pop_front());
                end
                if (!in_frame && exp_edge_q.size() > 0 && exp_edge_q[0] == edge_cnt) begin
                    d  = exp_q.pop_front();
                    pp = exp_par_q.pop_front();
                    void'(exp_edge_q.pop_front());
                    len  = frame_len(pp[1]);
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < W; i++) bits[i+1] = d[i];
                    if (pp[1]) bits[W+1] = pp[0];
                    in_frame = 1'b1;
                    pos = 0;
                end
                if (in_frame) begin
                    check($sformatf("frame_bit%0d", pos), TX_OUT, bits[pos]);
                    check("frame_busy", Busy, 1'b1);
                    pos++;
                    if (pos == len) in_frame = 1'b0;
                end else begin
                    check("idle_tx", TX_OUT, 1'b1);
                    check("idle_busy", Busy, 1'b0);
                end
            end
        end
    end

    // stimulus
    initial begin
        #1 RST = 1'b0;
        repeat (3) idle_cycle();
        release_reset();
        repeat (20) idle_cycle();

        // directed frames
        wait_free(); send(8'hA5, 1'b0, 1'b0);
        wait_free(); send(8'h03, 1'b1, 1'b0);
        wait_free(); send(8'h03, 1'b1, 1'b1);
        wait_free(); send(8'h07, 1'b1, 1'b0);

        // request during a frame is dropped, config changes do not leak in
        wait_free(); send(8'h55, 1'b0, 1'b0);
        repeat (3) idle_cycle();
        send(8'hFF, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // valid held high: one idle cycle between frames
        wait_free(); send(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) send(8'h80, 1'b0, 1'b0);

        // async reset during data bit 3
        wait_free(); send(8'hC3, 1'b1, 1'b1);
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("async_reset_tx", TX_OUT, 1'b1);
        check("async_reset_busy", Busy, 1'b0);
        exp_q.delete();
        exp_par_q.delete();
        exp_edge_q.delete();
        repeat (2) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        release_reset();
        send(8'h3C, 1'b0, 1'b0);
        wait_free();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 3) == 0), W'($urandom),
                        1'($urandom), 1'($urandom));
        end

        // drain
        for (int i = 0; i < 60 && (exp_edge_q.size() > 0 || in_frame); i++) idle_cycle();
        repeat (2) idle_cycle();
        n_cmp++;
        if (exp_edge_q.size() != 0 || in_frame) begin
            n_err++;
            $display("FAIL drain: %0d frames still pending", exp_edge_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
